// File: rtl/stage_stall_ctrl_pkg.sv
// Shared definitions for the stage stall controller: pipeline stage numbers,
// FSM state type and a counter-width helper.
package stage_stall_ctrl_pkg;

    localparam logic [2:0] STAGE_FETCH = 3'd0;
    localparam logic [2:0] STAGE_MEM   = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bits needed to hold 0..maxval, never less than one.
    function automatic int cnt_width(input int maxval);
        return (maxval <= 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/stage_stall_ctrl_wait_counter.sv
// Loadable down-counter that saturates at zero; zero_o flags the end of the
// wait-state window.
module stall_wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/stage_stall_ctrl.sv
// Stalls the stage counter while a fetch or load/store bus access is pending,
// runs the bus req/ack handshake with wait states and a timeout escape.
module stage_stall_ctrl
    import stage_stall_ctrl_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] stage,
    input  logic       mem_op,
    input  logic       bus_ack,
    output logic       blocked,
    output logic       bus_req,
    output logic       bus_is_fetch,
    output logic       bus_err
);

    localparam int WCW = cnt_width(WAIT_STATES);
    localparam int TCW = cnt_width(TIMEOUT);

    state_e           state_q;
    logic             bus_req_q;
    logic             bus_is_fetch_q;
    logic             bus_err_q;
    logic             ack_seen_q;
    logic [TCW-1:0]   tmo_cnt_q;

    logic             access;
    logic             wait_zero;
    logic             ack_ok;
    logic             timeout;

    assign access  = (stage == STAGE_FETCH) || ((stage == STAGE_MEM) && mem_op);
    assign ack_ok  = (bus_ack || ack_seen_q) && wait_zero;
    assign timeout = (tmo_cnt_q == TCW'(TIMEOUT));

    // Loaded on the edge that starts the access, counted down through WAIT.
    stall_wait_counter #(
        .WIDTH (WCW)
    ) u_wait_cnt (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     ((state_q == ST_IDLE) && access),
        .load_val_i (WCW'(WAIT_STATES)),
        .dec_i      (state_q == ST_WAIT),
        .zero_o     (wait_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            bus_req_q      <= 1'b0;
            bus_is_fetch_q <= 1'b0;
            bus_err_q      <= 1'b0;
            ack_seen_q     <= 1'b0;
            tmo_cnt_q      <= '0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        state_q        <= ST_WAIT;
                        bus_req_q      <= 1'b1;
                        bus_is_fetch_q <= (stage == STAGE_FETCH);
                        tmo_cnt_q      <= '0;
                        ack_seen_q     <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    if (bus_ack) begin
                        ack_seen_q <= 1'b1;
                    end
                    // A qualifying ack takes priority over a coincident timeout.
                    if (ack_ok) begin
                        state_q    <= ST_DONE;
                        bus_req_q  <= 1'b0;
                        ack_seen_q <= 1'b0;
                    end else if (timeout) begin
                        state_q    <= ST_DONE;
                        bus_req_q  <= 1'b0;
                        bus_err_q  <= 1'b1;
                        ack_seen_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    // DONE leaves blocked low for one cycle so the counter moves past the stage.
    assign blocked      = ((state_q == ST_IDLE) && access) || (state_q == ST_WAIT);
    assign bus_req      = bus_req_q;
    assign bus_is_fetch = bus_is_fetch_q;
    assign bus_err      = bus_err_q;

endmodule
